// File: rtl/mod_n_down_counter.sv
// ---------------------------------------------------------------------------
// mod_n_down_counter
//
// Synchronous modulo-N down counter. Counts N-1, N-2, ... 0 and then wraps
// back to N-1. The terminal-count/borrow output lets several instances be
// chained into multi-digit down counters and countdown timers: drive the
// enable of stage k+1 from the tc of stage k.
//
// Optional feature macro: MODN_DOWN_LOAD_EN
//   defined   -> load_i/din_i ports exist; a parallel load (clamped to N-1)
//                takes priority over counting.
//   undefined -> only reset, count enable and hold exist.
//
// Parameters:
//   N  modulus, legal range 2..256
//   W  count width, 2**W must be >= N (not checked here)
//
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   rst_i    synchronous active-high reset, count <- N-1
//   en_i     count enable, decrement by one per enabled cycle
//   load_i   parallel load strobe          (MODN_DOWN_LOAD_EN only)
//   din_i    parallel load value, W bits   (MODN_DOWN_LOAD_EN only)
//   count_o  current count, registered
//   tc_o     terminal count / borrow, combinational: en_i & (count == 0)
// ---------------------------------------------------------------------------
module mod_n_down_counter #(
  parameter int N = 7,
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
`ifdef MODN_DOWN_LOAD_EN
  input  logic         load_i,
  input  logic [W-1:0] din_i,
`endif
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  localparam logic [W-1:0] MaxVal = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] toggle;
  logic         atZero;

  // The borrow is purely combinational so a cascaded stage sees it in the
  // same cycle and decrements on the same edge as the wrapping stage.
  assign atZero  = (count_q == '0);
  assign tc_o    = en_i & atZero;
  assign count_o = count_q;

  // T-flip-flop toggle chain for decrementing: bit 0 toggles on every
  // enabled cycle, bit i toggles when every lower bit is already zero
  // (that is exactly when a borrow ripples up to it). A running AND is
  // kept in a block-local variable so the chain has no self-feedback.
  always_comb begin
    logic runZero;
    toggle  = '0;
    runZero = en_i;
    for (int i = 0; i < W; i++) begin
      toggle[i] = runZero;
      runZero   = runZero & ~count_q[i];
    end
  end

  // Next-state selection. Wrap replaces the toggle path with a direct
  // write of N-1 because the plain decrement of zero would go to all-ones,
  // which is outside the modulus for any N that is not a power of two.
  // A load, when present, overrides both and clamps out-of-range values
  // rather than letting them wrap.
  always_comb begin
    count_d = count_q;
    if (tc_o) begin
      count_d = MaxVal;
    end else begin
      count_d = count_q ^ toggle;
    end
`ifdef MODN_DOWN_LOAD_EN
    if (load_i) begin
      count_d = (din_i > MaxVal) ? MaxVal : din_i;
    end
`endif
  end

  // State register with synchronous reset, which beats load and enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= MaxVal;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_n_down_counter
//
// Self-checking bench for mod_n_down_counter. A single N=7 instance covers
// reset, counting, gating and (when MODN_DOWN_LOAD_EN is defined) load,
// clamping and priority. Two N=10 instances chained tc->en form a two-digit
// countdown. An arithmetic model of both follows the inputs and is compared
// against the outputs on every falling edge; directed steps also compare
// against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_mod_n_down_counter;

  localparam int TbN   = 7;
  localparam int TbW   = 3;
  localparam int CascN = 10;
  localparam int CascW = 4;

  logic           clk;
  logic           tbRst;
  logic           tbEn;
  logic           tbLoad;
  logic [TbW-1:0] tbDin;
  logic [TbW-1:0] dutCount;
  logic           dutTc;

  logic             cascRst;
  logic             cascEn;
  logic [CascW-1:0] count0;
  logic [CascW-1:0] count1;
  logic             tc0;
  logic             tc1;

  int checks   = 0;
  int failures = 0;

  int modelCount = 0;
  bit mainValid  = 1'b0;
  int cascTotal  = 0;
  bit cascValid  = 1'b0;

  mod_n_down_counter #(.N(TbN), .W(TbW)) u_dut (
    .clk_i   (clk),
    .rst_i   (tbRst),
    .en_i    (tbEn),
`ifdef MODN_DOWN_LOAD_EN
    .load_i  (tbLoad),
    .din_i   (tbDin),
`endif
    .count_o (dutCount),
    .tc_o    (dutTc)
  );

  mod_n_down_counter #(.N(CascN), .W(CascW)) u_stage0 (
    .clk_i   (clk),
    .rst_i   (cascRst),
    .en_i    (cascEn),
`ifdef MODN_DOWN_LOAD_EN
    .load_i  (1'b0),
    .din_i   ('0),
`endif
    .count_o (count0),
    .tc_o    (tc0)
  );

  mod_n_down_counter #(.N(CascN), .W(CascW)) u_stage1 (
    .clk_i   (clk),
    .rst_i   (cascRst),
    .en_i    (tc0),
`ifdef MODN_DOWN_LOAD_EN
    .load_i  (1'b0),
    .din_i   ('0),
`endif
    .count_o (count1),
    .tc_o    (tc1)
  );

  initial assert ((1 << TbW) >= TbN && (1 << CascW) >= CascN);

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: plain modular arithmetic on the count value. The
  // cascade is modelled as one two-digit number counting down mod 100.
  always @(posedge clk) begin
    if (tbRst) begin
      modelCount <= TbN - 1;
      mainValid  <= 1'b1;
    end else if (tbLoad) begin
      modelCount <= (int'(tbDin) > TbN - 1) ? TbN - 1 : int'(tbDin);
    end else if (tbEn) begin
      modelCount <= (modelCount == 0) ? TbN - 1 : modelCount - 1;
    end

    if (cascRst) begin
      cascTotal <= CascN * CascN - 1;
      cascValid <= 1'b1;
    end else if (cascEn) begin
      cascTotal <= (cascTotal == 0) ? CascN * CascN - 1 : cascTotal - 1;
    end
  end

  // Every-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit expTc;
    bit expTc0;
    bit expTc1;
    int expC0;
    int expC1;
    if (mainValid) begin
      expTc = tbEn && (modelCount == 0);
      checks++;
      if (int'(dutCount) != modelCount || dutTc !== expTc) begin
        failures++;
        $display("[TB] FAIL model_main: count=%0d tc=%0b, expected count=%0d tc=%0b",
                 dutCount, dutTc, modelCount, expTc);
      end
    end
    if (cascValid) begin
      expC0  = cascTotal % CascN;
      expC1  = cascTotal / CascN;
      expTc0 = cascEn && (expC0 == 0);
      expTc1 = expTc0 && (expC1 == 0);
      checks++;
      if (int'(count0) != expC0 || int'(count1) != expC1 ||
          tc0 !== expTc0 || tc1 !== expTc1) begin
        failures++;
        $display("[TB] FAIL model_cascade: c1=%0d c0=%0d tc1=%0b tc0=%0b, expected c1=%0d c0=%0d tc1=%0b tc0=%0b",
                 count1, count0, tc1, tc0, expC1, expC0, expTc1, expTc0);
      end
    end
  end

  // Drive the single counter's inputs and let combinational tc settle.
  task automatic applyStimulus(input logic r, input logic e,
                               input logic l, input logic [TbW-1:0] d);
    tbRst  = r;
    tbEn   = e;
    tbLoad = l;
    tbDin  = d;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the single counter against hand-computed literals.
  task automatic checkOutput(input string name, input int expCount, input bit expTc);
    checks++;
    if (int'(dutCount) != expCount || dutTc !== expTc) begin
      failures++;
      $display("[TB] FAIL %s: count=%0d tc=%0b, expected count=%0d tc=%0b",
               name, dutCount, dutTc, expCount, expTc);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    int sweepExp [14] = '{6, 5, 4, 3, 2, 1, 0, 6, 5, 4, 3, 2, 1, 0};
    int enPat    [4]  = '{1, 0, 1, 0};
    int gateExp  [4]  = '{5, 5, 4, 4};
    int loadRun  [4]  = '{3, 2, 1, 0};
    int stage1Changes = 0;
    logic [CascW-1:0] prevCount1;

    cascRst = 1'b1;
    cascEn  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Reset with enable low, then three idle cycles holding at N-1.
    $display("[TB] reset and idle hold");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("reset_hold", 6, 1'b0);
      if (i < 3) tick();
    end

    // Two full periods of continuous enable; tc only on the zero cycles.
    $display("[TB] full sweep");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("sweep", sweepExp[i], sweepExp[i] == 0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("sweep_end", 6, 1'b0);

`ifdef MODN_DOWN_LOAD_EN
    $display("[TB] load, clamp and priority");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("load_run", loadRun[i], i == 3);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("load_wrap", 6, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("load_two", 2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("load_clamp", 6, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("rst_over_load", 6, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4);
    checkOutput("load_en_tc", 0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("load_over_en", 4, 1'b0);
`endif

    // Enable gating from N-1, then a reset in the middle of counting.
    $display("[TB] enable gating and mid-count reset");
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, enPat[i] != 0, 1'b0, '0);
      tick();
      checkOutput("gate", gateExp[i], 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("mid_pre", 3, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("mid_rst", 6, 1'b0);

    // Two-digit cascade: 100 enabled cycles from 99 return to 99, and the
    // tens digit moves once per units wrap.
    $display("[TB] cascade");
    tick();
    checkValue("casc_reset_c0", int'(count0), 9);
    checkValue("casc_reset_c1", int'(count1), 9);
    cascRst = 1'b0;
    cascEn  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      prevCount1 = count1;
      tick();
      if (count1 != prevCount1) stage1Changes++;
    end
    cascEn = 1'b0;
    #1;
    checkValue("casc_end_c0", int'(count0), 9);
    checkValue("casc_end_c1", int'(count1), 9);
    checkValue("casc_stage1_steps", stage1Changes, 10);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
